lcd_hd44780_writer: RTL and testbench

//  Downstream stage of the LCD text path. Takes a 256-bit, 32-character ASCII frame
//  (line 1 = text[255:128], line 2 = text[127:0], MSB char first) and drives an
//  HD44780-compatible 16x2 character LCD in 8-bit, write-only mode.

---
 rtl/lcd_hd44780_writer_if.sv | 22 ++
 rtl/lcd_hd44780_writer.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_hd44780_writer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_writer_if.sv
// HD44780 8-bit write-only LCD bus bundle.
// master: driver side (rs, rw, en, data out); slave: panel side (inputs).
interface lcd_hd44780_writer_if;
    logic       disp_rs;
    logic       disp_rw;
    logic       disp_en;
    logic [7:0] disp_data;

    modport master (
        output disp_rs,
        output disp_rw,
        output disp_en,
        output disp_data
    );

    modport slave (
        input disp_rs,
        input disp_rw,
        input disp_en,
        input disp_data
    );
endinterface

// File: rtl/lcd_hd44780_writer.sv
// Drives a 32-char frame onto a 16x2 HD44780 LCD (8-bit, write-only).
// Ports: disp_clk, disp_async_rst (async, active-low), text[255:0],
//   bus (lcd_hd44780_writer_if.master), ready, frame_done.
// Optional: LCD_CHANGE_ONLY_EN defined -> idle until text differs.
module lcd_hd44780_writer #(
    parameter int unsigned TICK_DIV      = 32768,
    parameter int unsigned POWERON_TICKS = 24,
    parameter int unsigned CLEAR_TICKS   = 4
) (
    input  logic                        disp_clk,
    input  logic                        disp_async_rst,
    input  logic [255:0]                text,
    lcd_hd44780_writer_if.master        bus,
    output logic                        ready,
    output logic                        frame_done
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CLR_WAIT,
        SET_L1,
        LINE1,
        SET_L2,
        LINE2
`ifdef LCD_CHANGE_ONLY_EN
        , IDLE
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_C
    } phase_t;

    logic [CW-1:0]   div_cnt;
    logic            tick;
    state_t          state;
    phase_t          ph;
    logic [3:0]      idx;
    logic [3:0]      nidx;
    logic [15:0]     wait_cnt;
    logic [31:0][7:0] fb;
    logic            rs_q;
    logic            en_q;
    logic [7:0]      data_q;

    assign nidx          = idx + 4'd1;
    assign bus.disp_rs   = rs_q;
    assign bus.disp_rw   = 1'b0;
    assign bus.disp_en   = en_q;
    assign bus.disp_data = data_q;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        logic [7:0] c;
        unique case (i)
            3'd0, 3'd1, 3'd2, 3'd3: c = 8'h38;
            3'd4:                   c = 8'h08;
            3'd5:                   c = 8'h01;
            3'd6:                   c = 8'h06;
            3'd7:                   c = 8'h0C;
        endcase
        return c;
    endfunction

    // Registered tick: one cycle after the counter hits TICK_DIV-1.
    always_ff @(posedge disp_clk or negedge disp_async_rst) begin
        if (!disp_async_rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == CW'(TICK_DIV - 1));
            if (div_cnt == CW'(TICK_DIV - 1))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    // Each tick moves one bus phase; the C-phase exit tick also
    // loads the next byte (entering its phase A) or a wait state.
    // fb is indexed {line1, ~char}: fb[31] is the first line-1 char.
    always_ff @(posedge disp_clk or negedge disp_async_rst) begin
        if (!disp_async_rst) begin
            state      <= PWR_WAIT;
            ph         <= PH_A;
            idx        <= '0;
            wait_cnt   <= '0;
            fb         <= '0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            data_q     <= 8'h00;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    PWR_WAIT: begin
                        if (wait_cnt == 16'(POWERON_TICKS - 1)) begin
                            wait_cnt <= '0;
                            state    <= INIT;
                            idx      <= '0;
                            ph       <= PH_A;
                            rs_q     <= 1'b0;
                            data_q   <= 8'h38;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    CLR_WAIT: begin
                        if (wait_cnt == 16'(CLEAR_TICKS - 1)) begin
                            wait_cnt <= '0;
                            state    <= INIT;
                            idx      <= 4'd6;
                            ph       <= PH_A;
                            data_q   <= init_cmd(3'd6);
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
`ifdef LCD_CHANGE_ONLY_EN
                    IDLE: begin
                        if (text != fb) begin
                            fb     <= text;
                            state  <= SET_L1;
                            idx    <= '0;
                            ph     <= PH_A;
                            rs_q   <= 1'b0;
                            data_q <= 8'h80;
                        end
                    end
`endif
                    default: begin
                        unique case (ph)
                            PH_A: begin
                                en_q <= 1'b1;
                                ph   <= PH_B;
                            end
                            PH_B: begin
                                en_q <= 1'b0;
                                ph   <= PH_C;
                            end
                            default: begin
                                ph <= PH_A;
                                case (state)
                                    INIT: begin
                                        if (idx == 4'd5) begin
                                            state    <= CLR_WAIT;
                                            wait_cnt <= '0;
                                        end else if (idx == 4'd7) begin
                                            ready  <= 1'b1;
                                            fb     <= text;
                                            state  <= SET_L1;
                                            idx    <= '0;
                                            data_q <= 8'h80;
                                        end else begin
                                            idx    <= nidx;
                                            data_q <= init_cmd(nidx[2:0]);
                                        end
                                    end
                                    SET_L1: begin
                                        state  <= LINE1;
                                        idx    <= '0;
                                        rs_q   <= 1'b1;
                                        data_q <= fb[31];
                                    end
                                    LINE1: begin
                                        if (idx == 4'd15) begin
                                            state  <= SET_L2;
                                            idx    <= '0;
                                            rs_q   <= 1'b0;
                                            data_q <= 8'hC0;
                                        end else begin
                                            idx    <= nidx;
                                            data_q <= fb[{1'b1, ~nidx}];
                                        end
                                    end
                                    SET_L2: begin
                                        state  <= LINE2;
                                        idx    <= '0;
                                        rs_q   <= 1'b1;
                                        data_q <= fb[15];
                                    end
                                    LINE2: begin
                                        if (idx == 4'd15) begin
                                            frame_done <= 1'b1;
                                            idx        <= '0;
                                            rs_q       <= 1'b0;
`ifdef LCD_CHANGE_ONLY_EN
                                            state      <= IDLE;
`else
                                            fb         <= text;
                                            state      <= SET_L1;
                                            data_q     <= 8'h80;
`endif
                                        end else begin
                                            idx    <= nidx;
                                            data_q <= fb[{1'b0, ~nidx}];
                                        end
                                    end
                                    default: state <= PWR_WAIT;
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Randomized self-checking bench for lcd_hd44780_writer.
// Expected byte stream is built from the frame text; bus timing is monitored.
module tb_lcd_hd44780_writer;
    logic         disp_clk = 1'b0;
    logic         disp_async_rst = 1'b0;
    logic [255:0] text;
    logic         ready;
    logic         frame_done;

    lcd_hd44780_writer_if bus ();

    lcd_hd44780_writer #(
        .TICK_DIV      (4),
        .POWERON_TICKS (2),
        .CLEAR_TICKS   (2)
    ) dut (
        .disp_clk       (disp_clk),
        .disp_async_rst (disp_async_rst),
        .text           (text),
        .bus            (bus),
        .ready          (ready),
        .frame_done     (frame_done)
    );

    always #5 disp_clk = ~disp_clk;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         t_fall;
    } cap_t;

    cap_t capq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_rise = 0;
    int   n_fd = 0;
    int   t_rise = 0;
    int   rise80 = 0;
    int   last_chg = 0;
    int   last_fall = -1000;
    logic en_prev = 1'b0;
    logic fd_prev = 1'b0;
    logic [8:0] bus_prev = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int clamp4(input int v);
        return (v >= 4) ? 4 : v;
    endfunction

    always @(posedge disp_clk) cyc++;

    // Bus timing monitor and byte capture on each en fall.
    always @(negedge disp_clk) begin
        if (!disp_async_rst) begin
            en_prev  = 1'b0;
            fd_prev  = 1'b0;
            bus_prev = {bus.disp_rs, bus.disp_data};
        end else begin
            if ({bus.disp_rs, bus.disp_data} != bus_prev) begin
                chk("hold_after_fall", clamp4(cyc - last_fall), 4);
                last_chg = cyc;
                bus_prev = {bus.disp_rs, bus.disp_data};
            end
            if (bus.disp_en && !en_prev) begin
                chk("setup_before_rise", clamp4(cyc - last_chg), 4);
                t_rise = cyc;
                n_rise++;
                if ({bus.disp_rs, bus.disp_data} == 9'h080) rise80 = cyc;
            end
            if (!bus.disp_en && en_prev) begin
                chk("en_width", cyc - t_rise, 4);
                last_fall = cyc;
                capq.push_back('{bus.disp_rs, bus.disp_data, cyc});
            end
            if (frame_done) begin
                chk("fd_latency", cyc - rise80 + 4, 408);
                chk("fd_width", fd_prev, 0);
                n_fd++;
            end
            chk("rw_zero", bus.disp_rw, 0);
            en_prev = bus.disp_en;
            fd_prev = frame_done;
        end
    end

    task automatic get_byte(output cap_t c);
        int n = 0;
        while (capq.size() == 0 && n < 2000) begin
            @(negedge disp_clk);
            n++;
        end
        if (capq.size() == 0) begin
            chk("byte_timeout", capq.size(), 1);
            c = '{1'b0, 8'h00, 0};
        end else begin
            c = capq.pop_front();
        end
    endtask

    task automatic do_init();
        logic [7:0] exp_init [8];
        cap_t c;
        int n;
        int t01;
        exp_init = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        disp_async_rst = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge disp_clk);
            n++;
            if (bus.disp_en) break;
        end
        chk("first_rise_cycle", n, 13);
        chk("first_rise_data", {bus.disp_rs, bus.disp_data}, 9'h038);
        t01 = 0;
        for (int k = 0; k < 8; k++) begin
            get_byte(c);
            chk($sformatf("init_b%0d", k), {c.rs, c.d}, {1'b0, exp_init[k]});
            if (k == 5) t01 = c.t_fall;
            if (k == 6) chk("clr_gap", (c.t_fall - t01 >= 20) ? 20 : c.t_fall - t01, 20);
            if (k == 7) chk("ready_before_end", ready, 0);
        end
        n = 0;
        while (!ready && n < 10) begin
            @(negedge disp_clk);
            n++;
        end
        chk("ready_rise", ready, 1);
    endtask

    task automatic check_frame(input logic [255:0] t, input int chg_at,
                               input logic [255:0] nt);
        cap_t c;
        logic [8:0] exp;
        for (int k = 0; k < 34; k++) begin
            if (k == 0) exp = 9'h080;
            else if (k == 17) exp = 9'h0C0;
            else if (k < 17) exp = {1'b1, t[255 - 8 * (k - 1) -: 8]};
            else exp = {1'b1, t[127 - 8 * (k - 18) -: 8]};
            get_byte(c);
            chk($sformatf("frame_b%0d", k), {c.rs, c.d}, exp);
            if (k == chg_at) text = nt;
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] t1, t2, t3, f2, t5;
        cap_t c;
        int n, r0;
        t1 = "Laser Lift      BattleBoard     ";
        t2 = rand256();
        t3 = rand256();
        t3[255:248] = 8'h00;
        t3[7:0] = 8'hFF;
        text = t1;
        disp_async_rst = 1'b0;
        repeat (10) @(negedge disp_clk);
        chk("rst_rs", bus.disp_rs, 0);
        chk("rst_rw", bus.disp_rw, 0);
        chk("rst_en", bus.disp_en, 0);
        chk("rst_data", bus.disp_data, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fd", frame_done, 0);

        do_init();
        check_frame(t1, -1, t1);
`ifdef LCD_CHANGE_ONLY_EN
        text = t2;
        f2 = t2;
`else
        f2 = t1;
`endif
        check_frame(f2, 5, t3);
        check_frame(t3, -1, t3);
        repeat (8) @(negedge disp_clk);
        chk("fd_count", n_fd, 3);
        chk("ready_held", ready, 1);

`ifdef LCD_CHANGE_ONLY_EN
        text = t1;
`endif
        for (int k = 0; k < 18; k++) get_byte(c);
        n = 0;
        while (!bus.disp_en && n < 50) begin
            @(negedge disp_clk);
            n++;
        end
        chk("line2_en_seen", bus.disp_en, 1);
        #2 disp_async_rst = 1'b0;
        #1;
        chk("rst_mid_en", bus.disp_en, 0);
        chk("rst_mid_ready", ready, 0);
        capq.delete();
        repeat (10) @(negedge disp_clk);
        do_init();
        check_frame(text, -1, text);

`ifdef LCD_CHANGE_ONLY_EN
        repeat (8) @(negedge disp_clk);
        r0 = n_rise;
        repeat (1000) @(negedge disp_clk);
        chk("idle_quiet", n_rise, r0);
        t5 = text;
        t5[$urandom_range(31) * 8 +: 8] ^= 8'h5A;
        text = t5;
        check_frame(t5, -1, t5);
`else
        r0 = n_rise;
        repeat (20) @(negedge disp_clk);
        chk("refresh_continues", n_rise > r0, 1);
        t5 = '0;
`endif
        repeat (4) @(negedge disp_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
